// File: rtl/asic_top_core_if.sv
// Pad-side bundle between the pad ring and the IP1 core: GPIO word, done flag,
// pad-drive enable, and the input data byte/strobe.
interface asic_top_core_if;
   logic [31:0] gpio;
   logic        done;
   logic        drive;
   logic [7:0]  din;
   logic        stb;

   modport master (output gpio, done, drive, input  din, stb);
   modport slave  (input  gpio, done, drive, output din, stb);
endinterface

// File: rtl/asic_top_core.sv
// Pad-level top with one IP: boot-ROM stream, then 2x2 byte-matrix squaring.
// Define ASIC_TOP_BOOTROM_EN to include the boot ROM and BOOT state.
module asic_top_ip1 (
   input  logic            clk_i,
   input  logic            rst_i,
   input  logic            en_i,
   asic_top_core_if.master bus
);
`ifdef ASIC_TOP_BOOTROM_EN
   typedef enum logic [1:0] {S_BOOT, S_WAIT, S_COMPUTE, S_DONE} state_e;
   localparam state_e S_INIT = S_BOOT;

   function automatic logic [31:0] rom_word(input logic [7:0] a);
      return {8'hB0, 8'h07, 8'h00, a};
   endfunction
`else
   typedef enum logic [1:0] {S_WAIT, S_COMPUTE, S_DONE} state_e;
   localparam state_e S_INIT = S_WAIT;
`endif

   state_e      state_q, state_d;
   logic [1:0]  sync_q;
   logic        stb_prev_q;
   logic [1:0]  cnt_q, cnt_d;
   logic [7:0]  elem_q [4];
   logic [7:0]  elem_d [4];
   logic [31:0] result_q, result_d;
   logic [7:0]  addr_q, addr_d;
   logic        stb_rise;
   logic [7:0]  r00, r01, r10, r11;

   assign stb_rise  = sync_q[1] & ~stb_prev_q;
   assign bus.drive = en_i & ~rst_i;

   // Only the low byte of each 17-bit sum is kept, so mod-256 arithmetic is exact.
   assign r00 = elem_q[0] * elem_q[0] + elem_q[1] * elem_q[2];
   assign r01 = elem_q[0] * elem_q[1] + elem_q[1] * elem_q[3];
   assign r10 = elem_q[2] * elem_q[0] + elem_q[3] * elem_q[2];
   assign r11 = elem_q[2] * elem_q[1] + elem_q[3] * elem_q[3];

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q    <= S_INIT;
         sync_q     <= '0;
         stb_prev_q <= 1'b0;
         cnt_q      <= '0;
         elem_q     <= '{default: '0};
         result_q   <= '0;
         addr_q     <= '0;
      end else begin
         state_q    <= state_d;
         sync_q     <= en_i ? {sync_q[0], bus.stb} : 2'b00;
         stb_prev_q <= en_i & sync_q[1];
         cnt_q      <= cnt_d;
         elem_q     <= elem_d;
         result_q   <= result_d;
         addr_q     <= addr_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      elem_d   = elem_q;
      result_d = result_q;
      addr_d   = addr_q;
      bus.gpio = '0;
      bus.done = 1'b0;
      case (state_q)
`ifdef ASIC_TOP_BOOTROM_EN
         S_BOOT: begin
            bus.gpio = rom_word(addr_q);
            addr_d   = addr_q + 8'd1;
            if (addr_q == 8'hFF) state_d = S_WAIT;
         end
`endif
         S_WAIT: begin
            if (stb_rise) begin
               elem_d[cnt_q] = bus.din;
               cnt_d         = cnt_q + 2'd1;
               if (cnt_q == 2'd3) state_d = S_COMPUTE;
            end
         end
         S_COMPUTE: begin
            result_d = {r11, r10, r01, r00};
            state_d  = S_DONE;
         end
         S_DONE: begin
            bus.gpio = result_q;
            bus.done = 1'b1;
            if (stb_rise) begin
               result_d  = '0;
               elem_d[0] = bus.din;
               cnt_d     = 2'd1;
               state_d   = S_WAIT;
            end
         end
         default: state_d = S_INIT;
      endcase
      // Deselecting IP1 returns it to its post-reset state on the next clock.
      if (!en_i) begin
         state_d  = S_INIT;
         cnt_d    = '0;
         elem_d   = '{default: '0};
         result_d = '0;
         addr_d   = '0;
      end
   end
endmodule

module asic_top_core (
   input  logic sys_clk_i_pad,
   input  logic rst_pad,
   input  logic ip_sel_pad0, ip_sel_pad1, ip_sel_pad2,
   inout  wire  io_pad0,  io_pad1,  io_pad2,  io_pad3,  io_pad4,  io_pad5,  io_pad6,  io_pad7,
   inout  wire  io_pad8,  io_pad9,  io_pad10, io_pad11, io_pad12, io_pad13, io_pad14, io_pad15,
   inout  wire  io_pad16, io_pad17, io_pad18, io_pad19, io_pad20, io_pad21, io_pad22, io_pad23,
   inout  wire  io_pad24, io_pad25, io_pad26, io_pad27, io_pad28, io_pad29, io_pad30, io_pad31,
   inout  wire  io_pad32, io_pad33, io_pad34, io_pad35, io_pad36, io_pad37, io_pad38, io_pad39,
   inout  wire  io_pad40, io_pad41, io_pad42, io_pad43, io_pad44, io_pad45, io_pad46, io_pad47,
   inout  wire  io_pad48, io_pad49, io_pad50, io_pad51, io_pad52, io_pad53, io_pad54, io_pad55,
   inout  wire  io_pad56, io_pad57, io_pad58, io_pad59, io_pad60, io_pad61, io_pad62, io_pad63,
   inout  wire  io_pad64, io_pad65, io_pad66, io_pad67, io_pad68, io_pad69, io_pad70, io_pad71,
   inout  wire  io_pad72, io_pad73, io_pad74, io_pad75, io_pad76, io_pad77, io_pad78, io_pad79,
   inout  wire  io_pad80, io_pad81
);
   asic_top_core_if pif ();
   logic ip1_en;

   assign ip1_en   = ({ip_sel_pad2, ip_sel_pad1, ip_sel_pad0} == 3'b001);
   assign pif.din  = {io_pad39, io_pad38, io_pad37, io_pad36, io_pad35, io_pad34, io_pad33, io_pad32};
   assign pif.stb  = io_pad40;

   asic_top_ip1 u_ip1 (
      .clk_i (sys_clk_i_pad),
      .rst_i (rst_pad),
      .en_i  (ip1_en),
      .bus   (pif)
   );

   assign io_pad0  = pif.drive ? pif.gpio[0]  : 1'bz;  assign io_pad1  = pif.drive ? pif.gpio[1]  : 1'bz;
   assign io_pad2  = pif.drive ? pif.gpio[2]  : 1'bz;  assign io_pad3  = pif.drive ? pif.gpio[3]  : 1'bz;
   assign io_pad4  = pif.drive ? pif.gpio[4]  : 1'bz;  assign io_pad5  = pif.drive ? pif.gpio[5]  : 1'bz;
   assign io_pad6  = pif.drive ? pif.gpio[6]  : 1'bz;  assign io_pad7  = pif.drive ? pif.gpio[7]  : 1'bz;
   assign io_pad8  = pif.drive ? pif.gpio[8]  : 1'bz;  assign io_pad9  = pif.drive ? pif.gpio[9]  : 1'bz;
   assign io_pad10 = pif.drive ? pif.gpio[10] : 1'bz;  assign io_pad11 = pif.drive ? pif.gpio[11] : 1'bz;
   assign io_pad12 = pif.drive ? pif.gpio[12] : 1'bz;  assign io_pad13 = pif.drive ? pif.gpio[13] : 1'bz;
   assign io_pad14 = pif.drive ? pif.gpio[14] : 1'bz;  assign io_pad15 = pif.drive ? pif.gpio[15] : 1'bz;
   assign io_pad16 = pif.drive ? pif.gpio[16] : 1'bz;  assign io_pad17 = pif.drive ? pif.gpio[17] : 1'bz;
   assign io_pad18 = pif.drive ? pif.gpio[18] : 1'bz;  assign io_pad19 = pif.drive ? pif.gpio[19] : 1'bz;
   assign io_pad20 = pif.drive ? pif.gpio[20] : 1'bz;  assign io_pad21 = pif.drive ? pif.gpio[21] : 1'bz;
   assign io_pad22 = pif.drive ? pif.gpio[22] : 1'bz;  assign io_pad23 = pif.drive ? pif.gpio[23] : 1'bz;
   assign io_pad24 = pif.drive ? pif.gpio[24] : 1'bz;  assign io_pad25 = pif.drive ? pif.gpio[25] : 1'bz;
   assign io_pad26 = pif.drive ? pif.gpio[26] : 1'bz;  assign io_pad27 = pif.drive ? pif.gpio[27] : 1'bz;
   assign io_pad28 = pif.drive ? pif.gpio[28] : 1'bz;  assign io_pad29 = pif.drive ? pif.gpio[29] : 1'bz;
   assign io_pad30 = pif.drive ? pif.gpio[30] : 1'bz;  assign io_pad31 = pif.drive ? pif.gpio[31] : 1'bz;
   assign io_pad41 = pif.drive ? pif.done     : 1'bz;

   assign io_pad42 = 1'bz; assign io_pad43 = 1'bz; assign io_pad44 = 1'bz; assign io_pad45 = 1'bz;
   assign io_pad46 = 1'bz; assign io_pad47 = 1'bz; assign io_pad48 = 1'bz; assign io_pad49 = 1'bz;
   assign io_pad50 = 1'bz; assign io_pad51 = 1'bz; assign io_pad52 = 1'bz; assign io_pad53 = 1'bz;
   assign io_pad54 = 1'bz; assign io_pad55 = 1'bz; assign io_pad56 = 1'bz; assign io_pad57 = 1'bz;
   assign io_pad58 = 1'bz; assign io_pad59 = 1'bz; assign io_pad60 = 1'bz; assign io_pad61 = 1'bz;
   assign io_pad62 = 1'bz; assign io_pad63 = 1'bz; assign io_pad64 = 1'bz; assign io_pad65 = 1'bz;
   assign io_pad66 = 1'bz; assign io_pad67 = 1'bz; assign io_pad68 = 1'bz; assign io_pad69 = 1'bz;
   assign io_pad70 = 1'bz; assign io_pad71 = 1'bz; assign io_pad72 = 1'bz; assign io_pad73 = 1'bz;
   assign io_pad74 = 1'bz; assign io_pad75 = 1'bz; assign io_pad76 = 1'bz; assign io_pad77 = 1'bz;
   assign io_pad78 = 1'bz; assign io_pad79 = 1'bz; assign io_pad80 = 1'bz; assign io_pad81 = 1'bz;
endmodule

// File: tb/tb_asic_top_core.sv
// Scoreboard bench for asic_top_core: undriven pads are pulled up, so high-Z reads as 1.
module tb_asic_top_core;
   typedef struct { string name; logic [72:0] exp; } probe_t;
   typedef struct { logic [31:0] val; int unsigned deadline; } result_t;

   localparam logic [72:0] HIZ = '1;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [2:0]  sel = 3'b001;
   wire  [81:0] pad;
   int unsigned cyc   = 0;
   int unsigned n_vec = 0;
   int unsigned n_err = 0;
   probe_t      probe_q [$];
   result_t     res_q [$];
   probe_t      p_cur;
   result_t     r_cur;
   logic [72:0] got;
   logic        done_prev = 1'b0;

   asic_top_core_if tb_if ();

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   assign pad[39:32]  = tb_if.din;
   assign pad[40]     = tb_if.stb;
   assign tb_if.gpio  = pad[31:0];
   assign tb_if.done  = pad[41];
   assign tb_if.drive = (sel == 3'b001) && !rst;

   for (genvar i = 0; i < 82; i++) begin : g_pull
      if (i < 32 || i > 40) begin : g_on
         pullup (pad[i]);
      end
   end

   asic_top_core dut (
      .sys_clk_i_pad(clk), .rst_pad(rst),
      .ip_sel_pad0(sel[0]), .ip_sel_pad1(sel[1]), .ip_sel_pad2(sel[2]),
      .io_pad0(pad[0]),   .io_pad1(pad[1]),   .io_pad2(pad[2]),   .io_pad3(pad[3]),   .io_pad4(pad[4]),
      .io_pad5(pad[5]),   .io_pad6(pad[6]),   .io_pad7(pad[7]),   .io_pad8(pad[8]),   .io_pad9(pad[9]),
      .io_pad10(pad[10]), .io_pad11(pad[11]), .io_pad12(pad[12]), .io_pad13(pad[13]), .io_pad14(pad[14]),
      .io_pad15(pad[15]), .io_pad16(pad[16]), .io_pad17(pad[17]), .io_pad18(pad[18]), .io_pad19(pad[19]),
      .io_pad20(pad[20]), .io_pad21(pad[21]), .io_pad22(pad[22]), .io_pad23(pad[23]), .io_pad24(pad[24]),
      .io_pad25(pad[25]), .io_pad26(pad[26]), .io_pad27(pad[27]), .io_pad28(pad[28]), .io_pad29(pad[29]),
      .io_pad30(pad[30]), .io_pad31(pad[31]), .io_pad32(pad[32]), .io_pad33(pad[33]), .io_pad34(pad[34]),
      .io_pad35(pad[35]), .io_pad36(pad[36]), .io_pad37(pad[37]), .io_pad38(pad[38]), .io_pad39(pad[39]),
      .io_pad40(pad[40]), .io_pad41(pad[41]), .io_pad42(pad[42]), .io_pad43(pad[43]), .io_pad44(pad[44]),
      .io_pad45(pad[45]), .io_pad46(pad[46]), .io_pad47(pad[47]), .io_pad48(pad[48]), .io_pad49(pad[49]),
      .io_pad50(pad[50]), .io_pad51(pad[51]), .io_pad52(pad[52]), .io_pad53(pad[53]), .io_pad54(pad[54]),
      .io_pad55(pad[55]), .io_pad56(pad[56]), .io_pad57(pad[57]), .io_pad58(pad[58]), .io_pad59(pad[59]),
      .io_pad60(pad[60]), .io_pad61(pad[61]), .io_pad62(pad[62]), .io_pad63(pad[63]), .io_pad64(pad[64]),
      .io_pad65(pad[65]), .io_pad66(pad[66]), .io_pad67(pad[67]), .io_pad68(pad[68]), .io_pad69(pad[69]),
      .io_pad70(pad[70]), .io_pad71(pad[71]), .io_pad72(pad[72]), .io_pad73(pad[73]), .io_pad74(pad[74]),
      .io_pad75(pad[75]), .io_pad76(pad[76]), .io_pad77(pad[77]), .io_pad78(pad[78]), .io_pad79(pad[79]),
      .io_pad80(pad[80]), .io_pad81(pad[81])
   );

   // Expected view of {pad[81:41], pad[31:0]} while IP1 is driving.
   function automatic logic [72:0] act(input logic done, input logic [31:0] gpio);
      return {40'hFF_FFFF_FFFF, done, gpio};
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic probe(input string name, input logic [72:0] exp);
      probe_t p;
      p.name = name;
      p.exp  = exp;
      probe_q.push_back(p);
      step();
   endtask

   task automatic expect_result(input logic [31:0] val);
      result_t r;
      r.val      = val;
      r.deadline = cyc + 64;
      res_q.push_back(r);
   endtask

   task automatic send_byte(input logic [7:0] b);
      tb_if.din = b;
      tb_if.stb = 1'b1;
      repeat (4) step();
      tb_if.stb = 1'b0;
      repeat (4) step();
   endtask

   task automatic drain();
      for (int i = 0; i < 200 && res_q.size() != 0; i++) step();
   endtask

   task automatic send_group(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c,
                             input logic [7:0] d, input logic [31:0] exp);
      expect_result(exp);
      send_byte(a);
      send_byte(b);
      send_byte(c);
      send_byte(d);
      drain();
   endtask

   task automatic wait_init(input string tag);
`ifdef ASIC_TOP_BOOTROM_EN
      probe({tag, "_boot_first"}, act(1'b0, 32'hB0070000));
      repeat (254) step();
      probe({tag, "_boot_last"}, act(1'b0, 32'hB00700FF));
      probe({tag, "_boot_end"}, act(1'b0, 32'h0));
`else
      probe({tag, "_wait"}, act(1'b0, 32'h0));
`endif
   endtask

   // Monitor: consumes pad probes, result presentations, and result deadlines.
   always @(negedge clk) begin
      got = {pad[81:41], pad[31:0]};
      while (probe_q.size() != 0) begin
         p_cur = probe_q.pop_front();
         n_vec++;
         if (got !== p_cur.exp) begin
            n_err++;
            $display("FAIL %s: pads{81:41,31:0} got %h, want %h", p_cur.name, got, p_cur.exp);
         end
      end
      if (tb_if.drive && tb_if.done && !done_prev) begin
         n_vec++;
         if (res_q.size() == 0) begin
            n_err++;
            $display("FAIL unexpected_result: got %h, want no result", tb_if.gpio);
         end else begin
            r_cur = res_q.pop_front();
            if (tb_if.gpio !== r_cur.val) begin
               n_err++;
               $display("FAIL result: got %h, want %h", tb_if.gpio, r_cur.val);
            end
         end
      end else if (res_q.size() != 0 && cyc > res_q[0].deadline) begin
         r_cur = res_q.pop_front();
         n_vec++;
         n_err++;
         $display("FAIL result_timeout: got none by cycle %0d, want %h", cyc, r_cur.val);
      end
      done_prev = tb_if.drive && tb_if.done;
   end

   initial begin
      tb_if.din = '0;
      tb_if.stb = 1'b0;
      step();
      step();
      probe("reset_hiz", HIZ);
      rst = 1'b0;
`ifdef ASIC_TOP_BOOTROM_EN
      for (int i = 0; i < 256; i++) probe("boot_word", act(1'b0, {24'hB00700, 8'(i)}));
      probe("boot_end", act(1'b0, 32'h0));
`else
      probe("wait_after_reset", act(1'b0, 32'h0));
      probe("wait_hold", act(1'b0, 32'h0));
`endif

      send_group(8'd1, 8'd2, 8'd3, 8'd4, 32'h160F0A07);
      probe("done_hold", act(1'b1, 32'h160F0A07));

      // Strobe in DONE restarts collection with that byte as a.
      expect_result(32'h02080832);
      send_byte(8'd7);
      probe("done_cleared", act(1'b0, 32'h0));
      send_byte(8'd1);
      send_byte(8'd1);
      send_byte(8'd1);
      drain();

      send_group(8'd255, 8'd255, 8'd255, 8'd255, 32'h02020202);
      send_group(8'd2, 8'd3, 8'd4, 8'd5, 32'h251C1510);
      send_group(8'd5, 8'd0, 8'd0, 8'd9, 32'h51000019);
      send_group(8'd16, 8'd16, 8'd16, 8'd16, 32'h00000000);

      // Partial bytes are discarded by deselecting IP1.
      send_byte(8'd9);
      send_byte(8'd9);
      sel = 3'b000;
      probe("sel0_hiz", HIZ);
      send_byte(8'd1);
      sel = 3'b011;
      probe("sel3_hiz", HIZ);
      sel = 3'b001;
      wait_init("resel");
      send_group(8'd1, 8'd2, 8'd3, 8'd4, 32'h160F0A07);

      // Partial bytes are discarded by a reset pulse.
      send_byte(8'd5);
      send_byte(8'd6);
      send_byte(8'd7);
      rst = 1'b1;
      probe("midrun_reset_hiz", HIZ);
      rst = 1'b0;
      wait_init("rst");
      send_group(8'd1, 8'd2, 8'd3, 8'd4, 32'h160F0A07);

      drain();
      step();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule

// File: doc/asic_top_core.md
ASIC_TOP_CORE -- requirements
Module: asic_top_core

Interface
REQ-001 SHALL have port sys_clk_i_pad  input  1  single system clock; all logic on its rising edge.
REQ-002 SHALL have port rst_pad  input  1  asynchronous, active-high reset.
REQ-003 SHALL have ports ip_sel_pad0, ip_sel_pad1, ip_sel_pad2  input  1 each  IP select; ip_sel = {pad2,pad1,pad0}.
REQ-004 SHALL have ports io_pad0 … io_pad81  inout  1 each  general IO; io_pad[n] denotes io_padn below.
REQ-005 SHALL use io_pad[31:0] as output GPIO word, io_pad[39:32] as input data byte, io_pad[40] as input strobe, io_pad[41] as output done flag; io_pad[81:42] always high-Z.

Function
REQ-006 SHALL contain a 256 x 32 ROM, word[a] = {8'hB0, 8'h07, 8'h00, a[7:0]}, combinational read.
REQ-007 SHALL activate IP1 only when ip_sel == 3'b001; for any other value, all 82 pads high-Z and the IP1 FSM synchronously cleared to its post-reset state.
REQ-008 SHALL, when IP1 is active, drive io_pad[31:0] and io_pad[41]; io_pad[40:32] are never driven.
REQ-009 SHALL implement FSM states BOOT, WAIT, COMPUTE, DONE.
REQ-010 BOOT: 8-bit addr counts 0..255, one step per clock; io_pad[31:0] = ROM[addr]; io_pad[41] = 0; strobes ignored; after addr 255, go to WAIT.
REQ-011 WAIT: io_pad[31:0] = 0, io_pad[41] = 0; collect 4 bytes a, b, c, d in order, one per strobe event.
REQ-012 Strobe event: io_pad[40] through a 2-flop synchronizer; rising edge of the synchronized signal captures io_pad[39:32] (sampled on the same clock) into the element indexed by a 2-bit count.
REQ-013 SHALL go to COMPUTE on the clock the 4th byte is captured.
REQ-014 COMPUTE, one cycle: square the matrix [a b; c d] with unsigned arithmetic (17-bit intermediates):
- r00 = a*a + b*c
- r01 = a*b + b*d
- r10 = c*a + d*c
- r11 = c*b + d*d
REQ-015 SHALL register result = {r11[7:0], r10[7:0], r01[7:0], r00[7:0]} and go to DONE; each field is truncated to its low 8 bits.
REQ-016 DONE: io_pad[31:0] = result, io_pad[41] = 1; result visible on the 2nd clock after the 4th capture.
REQ-017 SHALL, on a strobe event in DONE, clear io_pad[41] and result, capture that byte as a, set count = 1, and go to WAIT.
REQ-018 SHALL restart from the post-reset state (BOOT or WAIT per REQ-023) when ip_sel changes away from and back to 3'b001.

Reset
REQ-019 SHALL, while rst_pad = 1, leave all pads high-Z.
REQ-020 SHALL, while rst_pad = 1, clear addr, count, elements, result and synchronizer flops.
REQ-021 SHALL, while rst_pad = 1, hold the FSM in its post-reset state.
REQ-022 SHALL start the first BOOT cycle (addr 0) on the first clock after rst_pad deasserts; reset mid-operation discards partial data.

Configuration
REQ-023 SHALL use macro ASIC_TOP_BOOTROM_EN:
- defined: ROM and BOOT state present; post-reset state is BOOT.
- undefined: ROM and BOOT omitted; post-reset state is WAIT and io_pad[31:0] = 0 until DONE.

Verification
REQ-024 ip_sel=1, macro on, release reset -> io_pad[31:0] = 0xB0070000, 0xB0070001 … 0xB00700FF on 256 consecutive clocks, then 0x00000000.
REQ-025 After boot, strobe bytes 1, 2, 3, 4 -> io_pad[31:0] = 0x160F0A07 and io_pad[41] = 1.
REQ-026 Strobe bytes 255, 255, 255, 255 (each field = 130050) -> io_pad[31:0] = 0x02020202.
REQ-027 ip_sel=0 -> all io pads Z; 2 bytes sent, ip_sel 1->0->1, bytes 1..4 -> 0x160F0A07 (earlier bytes discarded).
REQ-028 rst_pad pulsed after 3 bytes, then bytes 1..4 -> 0x160F0A07; macro off -> WAIT immediately after reset, io_pad[31:0] = 0 until DONE.
